// File: rtl/weighted_rr_lock_scheduler_pkg.sv
// Shared types and width helpers for the weighted round-robin lock scheduler.
package weighted_rr_lock_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int hcw(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/weighted_rr_lock_scheduler_if.sv
// Requester/weight-port bundle between the requester masters and the scheduler.
interface weighted_rr_lock_scheduler_if
    import weighted_rr_lock_scheduler_pkg::*;
#(
    parameter int N  = 8,
    parameter int WW = 4
);
    localparam int IDW = idw(N);

    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic           wt_we;
    logic [IDW-1:0] wt_idx;
    logic [WW-1:0]  wt_data;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;

    modport master (
        output req, done, wt_we, wt_idx, wt_data,
        input  gnt, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req, done, wt_we, wt_idx, wt_data,
        output gnt, gnt_valid, gnt_id, timeout
    );

endinterface

// File: rtl/weighted_rr_lock_scheduler_rr_first_pick.sv
// Rotating-priority search: first set request bit at or after start, wrapping.
module weighted_rr_lock_scheduler_rr_first_pick
    import weighted_rr_lock_scheduler_pkg::*;
#(
    parameter int N = 8,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int pos;

    // Walk offsets from the far end so the nearest hit is the final assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % N;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/weighted_rr_lock_scheduler.sv
// Weighted round-robin scheduler with grant lock, release turnaround and hold watchdog.
module weighted_rr_lock_scheduler
    import weighted_rr_lock_scheduler_pkg::*;
#(
    parameter int N          = 8,
    parameter int WW         = 4,
    parameter int MAX_HOLD   = 64,
    parameter int RST_WEIGHT = 1
) (
    input logic                          clk,
    input logic                          rst,
    weighted_rr_lock_scheduler_if.slave  bus
);

    localparam int IDW = idw(N);
    localparam int HCW = hcw(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

    state_t         state, state_nxt;
    logic [WW-1:0]  weight [N];
    logic [WW-1:0]  credit, credit_nxt;
    logic [IDW-1:0] last, last_nxt;
    logic [HCW-1:0] hold_cnt;
    logic [IDW-1:0] scan_start, scan_idx, pick_idx, gnt_id_nxt;
    logic [N-1:0]   gnt_nxt;
    logic           scan_found, keep_last, release_now, expire, timeout_nxt;

    assign scan_start = (last == LAST_IDX) ? '0 : last + 1'b1;

    weighted_rr_lock_scheduler_rr_first_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .start (scan_start),
        .found (scan_found),
        .idx   (scan_idx)
    );

    assign keep_last   = bus.req[last] && (credit != '0);
    assign pick_idx    = keep_last ? last : scan_idx;
    // gnt_id always names the owner while in GRANT.
    assign release_now = bus.done[bus.gnt_id] || !bus.req[bus.gnt_id];
    assign expire      = !release_now && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (scan_found) state_nxt = GRANT;
            GRANT:   if (release_now || expire) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = bus.gnt;
        gnt_id_nxt  = bus.gnt_id;
        timeout_nxt = 1'b0;
        credit_nxt  = credit;
        last_nxt    = last;
        unique case (state)
            IDLE: begin
                if (scan_found) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    gnt_id_nxt        = pick_idx;
                    last_nxt          = pick_idx;
                    if (keep_last)
                        credit_nxt = credit - 1'b1;
                    else
                        credit_nxt = (weight[scan_idx] == '0) ? '0 : weight[scan_idx] - 1'b1;
                end
            end
            GRANT: begin
                if (release_now || expire) begin
                    gnt_nxt     = '0;
                    timeout_nxt = expire;
                    if (expire) credit_nxt = '0;
                end
            end
            default: gnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= '0;
            bus.timeout   <= 1'b0;
            credit        <= '0;
            last          <= LAST_IDX;
            hold_cnt      <= '0;
        end else begin
            bus.gnt       <= gnt_nxt;
            bus.gnt_valid <= |gnt_nxt;
            bus.gnt_id    <= gnt_id_nxt;
            bus.timeout   <= timeout_nxt;
            credit        <= credit_nxt;
            last          <= last_nxt;
            if (state != GRANT)
                hold_cnt <= '0;
            else if (hold_cnt != '1)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Weight writes land after the current cycle's pick, so a reload sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) weight[i] <= WW'(RST_WEIGHT);
        end else if (bus.wt_we && (32'(bus.wt_idx) < N)) begin
            weight[bus.wt_idx] <= bus.wt_data;
        end
    end

endmodule
